// File: rtl/sv_string_unescaper.sv
// Streaming decoder for SystemVerilog string-literal bodies.
// Raw body bytes in, decoded byte values out, one registered output stage.
// Multi-byte escapes (\ddd, \xdd) are sequenced by a small FSM. A non-digit byte that
// ends an escape is held for one cycle and then decoded in NORM ("reprocess").
module sv_string_unescaper #(
  parameter int unsigned MAX_LEN = 1024,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic [LEN_W-1:0] out_len,
  output logic             err_overflow,
  output logic             err_hex,
  output logic             err_dangling,
  output logic             err_too_long
);

  localparam logic [1:0] StNorm = 2'd0;
  localparam logic [1:0] StEsc  = 2'd1;
  localparam logic [1:0] StOct  = 2'd2;
  localparam logic [1:0] StHex  = 2'd3;

  logic [1:0]       r_state;
  logic [8:0]       r_val;
  logic [1:0]       r_cnt;
  logic             r_first;
  logic             r_out_valid;
  logic [7:0]       r_out_data;
  logic             r_out_last;
  logic [LEN_W-1:0] r_len;
  logic             r_err_ovf;
  logic             r_err_hex;
  logic             r_err_dang;
  logic             r_too_long;

  logic             w_can_load;
  logic             w_is_oct;
  logic             w_is_hex;
  logic [3:0]       w_hex_val;
  logic [7:0]       w_esc_map;
  logic             w_reproc;
  logic             w_emit;
  logic [7:0]       w_emit_data;
  logic             w_emit_last;
  logic             w_ovf;
  logic             w_hexe;
  logic             w_dang;
  logic [1:0]       w_nstate;
  logic [8:0]       w_nval;
  logic [1:0]       w_ncnt;
  logic             w_consume;
  logic             w_first;
  logic [LEN_W-1:0] w_len_base;
  logic             w_room;
  logic             w_load;
  logic             w_drop;

  assign w_can_load = !r_out_valid || out_ready;
  assign w_is_oct   = (in_data >= 8'h30) && (in_data <= 8'h37);

  // Hex digit classification and value.
  always_comb begin
    w_is_hex  = 1'b0;
    w_hex_val = in_data[3:0];
    if ((in_data >= 8'h30) && (in_data <= 8'h39)) begin
      w_is_hex = 1'b1;
    end else if (((in_data >= 8'h61) && (in_data <= 8'h66)) ||
                 ((in_data >= 8'h41) && (in_data <= 8'h46))) begin
      w_is_hex  = 1'b1;
      w_hex_val = in_data[3:0] + 4'd9;
    end
  end

  // Single-character escape translation; unknown escapes (and \\, \") pass through.
  always_comb begin
    case (in_data)
      8'h6E:   w_esc_map = 8'h0A;
      8'h74:   w_esc_map = 8'h09;
      8'h76:   w_esc_map = 8'h0B;
      8'h66:   w_esc_map = 8'h0C;
      8'h61:   w_esc_map = 8'h07;
      default: w_esc_map = in_data;
    endcase
  end

  // Decoder FSM next state and emit decision; only acts when the output stage can load.
  always_comb begin
    w_reproc    = 1'b0;
    w_emit      = 1'b0;
    w_emit_data = in_data;
    w_emit_last = 1'b0;
    w_ovf       = 1'b0;
    w_hexe      = 1'b0;
    w_dang      = 1'b0;
    w_nstate    = r_state;
    w_nval      = r_val;
    w_ncnt      = r_cnt;
    if (in_valid && w_can_load && !rst) begin
      case (r_state)
        StNorm: begin
          if (in_data == 8'h5C) begin
            if (in_last) begin
              w_emit      = 1'b1;
              w_emit_last = 1'b1;
              w_dang      = 1'b1;
            end else begin
              w_nstate = StEsc;
            end
          end else begin
            w_emit      = 1'b1;
            w_emit_last = in_last;
          end
        end
        StEsc: begin
          w_nstate = StNorm;
          if (w_is_oct) begin
            w_nval = {6'd0, in_data[2:0]};
            w_ncnt = 2'd1;
            if (in_last) begin
              w_emit      = 1'b1;
              w_emit_data = {5'd0, in_data[2:0]};
              w_emit_last = 1'b1;
            end else begin
              w_nstate = StOct;
            end
          end else if (in_data == 8'h78) begin
            w_nval = '0;
            w_ncnt = '0;
            if (in_last) begin
              w_emit      = 1'b1;
              w_emit_last = 1'b1;
              w_hexe      = 1'b1;
            end else begin
              w_nstate = StHex;
            end
          end else begin
            w_emit      = 1'b1;
            w_emit_data = w_esc_map;
            w_emit_last = in_last;
          end
        end
        StOct: begin
          if (w_is_oct) begin
            w_nval = {r_val[5:0], in_data[2:0]};
            w_ncnt = r_cnt + 2'd1;
            if ((r_cnt == 2'd2) || in_last) begin
              w_emit      = 1'b1;
              w_emit_data = w_nval[7:0];
              w_emit_last = in_last;
              w_ovf       = w_nval[8];
              w_nstate    = StNorm;
            end
          end else begin
            // Flush pending value; the terminating byte is decoded next cycle in NORM.
            w_reproc    = 1'b1;
            w_emit      = 1'b1;
            w_emit_data = r_val[7:0];
            w_ovf       = r_val[8];
            w_nstate    = StNorm;
          end
        end
        default: begin
          if (w_is_hex) begin
            w_nval = {1'b0, r_val[3:0], w_hex_val};
            w_ncnt = r_cnt + 2'd1;
            if ((r_cnt == 2'd1) || in_last) begin
              w_emit      = 1'b1;
              w_emit_data = w_nval[7:0];
              w_emit_last = in_last;
              w_nstate    = StNorm;
            end
          end else begin
            w_reproc = 1'b1;
            w_emit   = 1'b1;
            w_nstate = StNorm;
            if (r_cnt == 2'd0) begin
              w_emit_data = 8'h78;
              w_hexe      = 1'b1;
            end else begin
              w_emit_data = r_val[7:0];
            end
          end
        end
      endcase
    end
  end

  assign in_ready   = w_can_load && !rst && !w_reproc;
  assign w_consume  = in_valid && in_ready;
  assign w_first    = w_consume && r_first;
  assign w_len_base = w_first ? '0 : r_len;
  assign w_room     = w_len_base < LEN_W'(MAX_LEN);
  // Past the limit only the frame terminator is still loaded (as 0x00).
  assign w_load     = w_emit && (w_room || w_emit_last);
  assign w_drop     = w_emit && !w_room;

  // FSM, output register, length counter and error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StNorm;
      r_val       <= '0;
      r_cnt       <= '0;
      r_first     <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_len       <= '0;
      r_err_ovf   <= 1'b0;
      r_err_hex   <= 1'b0;
      r_err_dang  <= 1'b0;
      r_too_long  <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_val   <= w_nval;
      r_cnt   <= w_ncnt;
      if (w_consume) begin
        r_first <= in_last;
      end
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_room ? w_emit_data : 8'h00;
        r_out_last  <= w_emit_last;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      r_len      <= w_len_base + ((w_load && w_room) ? LEN_W'(1) : LEN_W'(0));
      r_err_ovf  <= w_emit && w_ovf;
      r_err_hex  <= w_emit && w_hexe;
      r_err_dang <= w_emit && w_dang;
      r_too_long <= (w_first ? 1'b0 : r_too_long) | w_drop;
    end
  end

  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_last     = r_out_last;
  assign out_len      = r_len;
  assign err_overflow = r_err_ovf;
  assign err_hex      = r_err_hex;
  assign err_dangling = r_err_dang;
  assign err_too_long = r_too_long;

endmodule

// File: tb/tb_sv_string_unescaper.sv
// Self-checking bench for sv_string_unescaper: directed literals plus randomized literals
// checked against a software-style decoder of the escape rules.
module tb_sv_string_unescaper;

  localparam int unsigned MaxLen = 8;
  localparam int unsigned LenW   = $clog2(MaxLen + 1);

  typedef logic [7:0] bq_t[$];

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [7:0]      in_data;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [7:0]      out_data;
  logic            out_last;
  logic [LenW-1:0] out_len;
  logic            err_overflow;
  logic            err_hex;
  logic            err_dangling;
  logic            err_too_long;

  int checks = 0;
  int errors = 0;

  // Results of the most recent run_frame call.
  logic [7:0]      got_d[$];
  logic            got_l[$];
  logic [7:0]      stall_d[$];
  int              n_ovf;
  int              n_hex;
  int              n_dang;
  int              n_blocked;
  logic            fin_too_long;
  logic [LenW-1:0] fin_len;
  bit              timed_out;

  logic [7:0] pool[16] = '{8'h5C, 8'h5C, 8'h5C, 8'h6E, 8'h78, 8'h30, 8'h33, 8'h37,
                           8'h39, 8'h66, 8'h47, 8'h22, 8'h41, 8'h31, 8'h34, 8'h74};

  always #5 clk = ~clk;

  sv_string_unescaper #(.MAX_LEN(MaxLen)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_len      (out_len),
    .err_overflow (err_overflow),
    .err_hex      (err_hex),
    .err_dangling (err_dangling),
    .err_too_long (err_too_long)
  );

  function automatic bq_t s2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic int hexv(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    return -1;
  endfunction

  function automatic logic [7:0] esc(input logic [7:0] c);
    case (c)
      "n":     return 8'h0A;
      "t":     return 8'h09;
      "v":     return 8'h0B;
      "f":     return 8'h0C;
      "a":     return 8'h07;
      default: return c;
    endcase
  endfunction

  // Whole-literal reference decode, then the length limit applied to the result.
  function automatic void model(input bq_t raw, output bq_t ed, output int e_ovf,
                                output int e_hex, output int e_dang, output bit e_long,
                                output int e_len);
    bq_t        dec;
    int         i = 0;
    int         n = raw.size();
    int         v;
    int         k;
    logic [7:0] c;
    e_ovf = 0; e_hex = 0; e_dang = 0;
    ed.delete();
    while (i < n) begin
      c = raw[i]; i++;
      if (c != 8'h5C) dec.push_back(c);
      else if (i == n) begin
        dec.push_back(8'h5C); e_dang++;
      end else begin
        c = raw[i]; i++;
        if (c >= "0" && c <= "7") begin
          v = int'(c) - 48; k = 1;
          while (k < 3 && i < n && raw[i] >= "0" && raw[i] <= "7") begin
            v = v * 8 + int'(raw[i]) - 48; i++; k++;
          end
          dec.push_back(8'(v % 256));
          if (v > 255) e_ovf++;
        end else if (c == "x") begin
          v = 0; k = 0;
          while (k < 2 && i < n && hexv(raw[i]) >= 0) begin
            v = v * 16 + hexv(raw[i]); i++; k++;
          end
          if (k == 0) begin
            dec.push_back(8'h78); e_hex++;
          end else dec.push_back(8'(v));
        end else dec.push_back(esc(c));
      end
    end
    if (dec.size() > MaxLen) begin
      for (int j = 0; j < MaxLen; j++) ed.push_back(dec[j]);
      ed.push_back(8'h00);
      e_long = 1'b1;
      e_len  = MaxLen;
    end else begin
      ed     = dec;
      e_long = 1'b0;
      e_len  = dec.size();
    end
  endfunction

  // Drive one literal and collect its output frame. hold_first stalls out_ready for that many
  // cycles once the first output byte is visible, recording out_data during the stall.
  task automatic run_frame(input bq_t raw, input int gap_pct, input int stall_pct,
                           input int hold_first);
    int idx = 0;
    int cyc = 0;
    bit done = 0;
    bit v = 0;
    bit hs_in;
    int hold = 0;
    bit first_seen = 0;
    got_d.delete(); got_l.delete(); stall_d.delete();
    n_ovf = 0; n_hex = 0; n_dang = 0; n_blocked = 0; timed_out = 0;
    while (!done) begin
      @(negedge clk);
      if (!v && idx < raw.size()) v = ($urandom_range(99) >= gap_pct);
      in_valid = v;
      in_data  = v ? raw[idx] : 8'h00;
      in_last  = v && (idx == raw.size() - 1);
      if (hold_first > 0 && !first_seen && out_valid) begin
        first_seen = 1;
        hold       = hold_first;
      end
      out_ready = (hold > 0) ? 1'b0 : ($urandom_range(99) >= stall_pct);
      #4;
      if (hold > 0) begin
        stall_d.push_back(out_data);
        hold--;
      end
      n_ovf  += int'(err_overflow);
      n_hex  += int'(err_hex);
      n_dang += int'(err_dangling);
      if (in_valid && !in_ready) n_blocked++;
      hs_in = in_valid && in_ready;
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_l.push_back(out_last);
        if (out_last) done = 1;
      end
      @(posedge clk);
      if (hs_in) begin
        idx++;
        v = 0;
      end
      cyc++;
      if (cyc > 500) begin
        timed_out = 1;
        done      = 1;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    #4;
    fin_too_long = err_too_long;
    fin_len      = out_len;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, out_last, out_data} !== 10'd0) begin
      errors++; $display("FAIL reset_out: got v=%b l=%b d=%h, expected all 0", out_valid, out_last,
                         out_data);
    end
    checks++;
    if ({out_len, err_overflow, err_hex, err_dangling, err_too_long} !== '0) begin
      errors++; $display("FAIL reset_flags: got len=%0d ovf=%b hex=%b dang=%b long=%b, expected 0",
                         out_len, err_overflow, err_hex, err_dangling, err_too_long);
    end
    rst = 1'b0;
    #4;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp_d[2] = '{8'h41, 8'h0A};
    run_frame(s2q("A\\n"), 0, 0, 0);
    checks++;
    if (timed_out || got_d.size() != 2) begin
      errors++; $display("FAIL basic_count: got %0d bytes (timeout=%b), expected 2",
                         got_d.size(), timed_out);
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 1)) begin
          errors++; $display("FAIL basic_byte%0d: got %h/last=%b expected %h/last=%b", i,
                             got_d[i], got_l[i], exp_d[i], i == 1);
        end
      end
    end
    checks++;
    if (fin_len !== LenW'(2) || n_blocked != 0) begin
      errors++; $display("FAIL basic_len: got len=%0d blocked=%0d expected len=2 blocked=0",
                         fin_len, n_blocked);
    end
  endtask

  task automatic test_oct_hex();
    logic [7:0] exp_d[3] = '{8'hFF, 8'h00, 8'h5A};
    run_frame(s2q("\\377\\x0Z"), 0, 0, 0);
    checks++;
    if (timed_out || got_d.size() != 3) begin
      errors++; $display("FAIL octhex_count: got %0d bytes expected 3", got_d.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 2)) begin
          errors++; $display("FAIL octhex_byte%0d: got %h/last=%b expected %h/last=%b", i,
                             got_d[i], got_l[i], exp_d[i], i == 2);
        end
      end
    end
    checks++;
    if (n_blocked != 1 || n_ovf + n_hex + n_dang != 0) begin
      errors++; $display("FAIL octhex_flow: got blocked=%0d errs=%0d expected blocked=1 errs=0",
                         n_blocked, n_ovf + n_hex + n_dang);
    end
  endtask

  task automatic test_short_escapes();
    run_frame(s2q("\\11"), 0, 0, 0);
    checks++;
    if (got_d.size() != 1 || got_d[0] !== 8'h09 || got_l[0] !== 1'b1 ||
        n_ovf + n_hex + n_dang != 0) begin
      errors++; $display("FAIL short_oct: got n=%0d d=%h errs=%0d expected n=1 d=09 errs=0",
                         got_d.size(), (got_d.size() > 0) ? got_d[0] : 8'hxx,
                         n_ovf + n_hex + n_dang);
    end
    run_frame(s2q("\\b\\e"), 10, 10, 0);
    checks++;
    if (got_d.size() != 2 || got_d[0] !== 8'h62 || got_d[1] !== 8'h65 || got_l[0] !== 1'b0 ||
        got_l[1] !== 1'b1 || n_ovf + n_hex + n_dang != 0) begin
      errors++; $display("FAIL unknown_esc: got n=%0d, expected 62 65(last) with no errors",
                         got_d.size());
    end
  endtask

  task automatic test_errors();
    run_frame(s2q("\\400"), 0, 0, 0);
    checks++;
    if (got_d.size() != 1 || got_d[0] !== 8'h00 || got_l[0] !== 1'b1 || n_ovf != 1) begin
      errors++; $display("FAIL overflow: got n=%0d ovf=%0d expected 00(last) ovf=1",
                         got_d.size(), n_ovf);
    end
    run_frame(s2q("\\xg"), 0, 0, 0);
    checks++;
    if (got_d.size() != 2 || got_d[0] !== 8'h78 || got_d[1] !== 8'h67 || got_l[1] !== 1'b1 ||
        n_hex != 1) begin
      errors++; $display("FAIL hex_nodigit: got n=%0d hex=%0d expected 78 67(last) hex=1",
                         got_d.size(), n_hex);
    end
    run_frame(s2q("ab\\"), 0, 0, 0);
    checks++;
    if (got_d.size() != 3 || got_d[2] !== 8'h5C || got_l[2] !== 1'b1 || n_dang != 1) begin
      errors++; $display("FAIL dangling: got n=%0d dang=%0d expected 61 62 5C(last) dang=1",
                         got_d.size(), n_dang);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_d[5] = '{8'h61, 8'h62, 8'h22, 8'h63, 8'h64};
    run_frame(s2q("ab\\\"cd"), 0, 0, 3);
    checks++;
    if (stall_d.size() != 3) begin
      errors++; $display("FAIL stall_len: got %0d stalled samples expected 3", stall_d.size());
    end
    foreach (stall_d[i]) begin
      checks++;
      if (stall_d[i] !== 8'h61) begin
        errors++; $display("FAIL stall_hold%0d: got %h expected 61", i, stall_d[i]);
      end
    end
    checks++;
    if (got_d.size() != 5) begin
      errors++; $display("FAIL bp_count: got %0d bytes expected 5", got_d.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got_d[i] !== exp_d[i]) begin
          errors++; $display("FAIL bp_byte%0d: got %h expected %h", i, got_d[i], exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_too_long_and_reset();
    run_frame(s2q("0123456789"), 0, 0, 0);
    checks++;
    if (got_d.size() != MaxLen + 1 || got_d[MaxLen] !== 8'h00 || got_l[MaxLen] !== 1'b1) begin
      errors++; $display("FAIL too_long_frame: got %0d bytes expected %0d ending 00(last)",
                         got_d.size(), MaxLen + 1);
    end
    checks++;
    if (fin_too_long !== 1'b1 || fin_len !== LenW'(MaxLen)) begin
      errors++; $display("FAIL too_long_flag: got long=%b len=%0d expected long=1 len=%0d",
                         fin_too_long, fin_len, MaxLen);
    end
    // Leave the decoder mid-octal, then reset.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = (i == 0) ? 8'h5C : 8'h31; in_last = 1'b0; out_ready = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_frame(s2q("Q"), 0, 0, 0);
    checks++;
    if (got_d.size() != 1 || got_d[0] !== 8'h51 || got_l[0] !== 1'b1) begin
      errors++; $display("FAIL reset_mid_oct: got n=%0d expected single 51(last)", got_d.size());
    end
    checks++;
    if (fin_len !== LenW'(1) || fin_too_long !== 1'b0) begin
      errors++; $display("FAIL reset_mid_len: got len=%0d long=%b expected len=1 long=0",
                         fin_len, fin_too_long);
    end
  endtask

  task automatic test_random();
    bq_t raw;
    bq_t ed;
    int  e_ovf;
    int  e_hex;
    int  e_dang;
    bit  e_long;
    int  e_len;
    int  n;
    for (int f = 0; f < 60; f++) begin
      raw.delete();
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) raw.push_back(pool[$urandom_range(0, 15)]);
      model(raw, ed, e_ovf, e_hex, e_dang, e_long, e_len);
      run_frame(raw, $urandom_range(0, 40), $urandom_range(0, 40), 0);
      checks++;
      if (timed_out || got_d.size() != ed.size()) begin
        errors++; $display("FAIL rand%0d_count: got %0d bytes (timeout=%b) expected %0d", f,
                           got_d.size(), timed_out, ed.size());
        continue;
      end
      foreach (ed[i]) begin
        checks++;
        if (got_d[i] !== ed[i] || got_l[i] !== (i == ed.size() - 1)) begin
          errors++; $display("FAIL rand%0d_byte%0d: got %h/last=%b expected %h/last=%b", f, i,
                             got_d[i], got_l[i], ed[i], i == ed.size() - 1);
        end
      end
      checks++;
      if (n_ovf != e_ovf || n_hex != e_hex || n_dang != e_dang) begin
        errors++; $display("FAIL rand%0d_err: got ovf=%0d hex=%0d dang=%0d expected %0d %0d %0d",
                           f, n_ovf, n_hex, n_dang, e_ovf, e_hex, e_dang);
      end
      checks++;
      if (fin_too_long !== e_long || fin_len !== LenW'(e_len)) begin
        errors++; $display("FAIL rand%0d_len: got long=%b len=%0d expected long=%b len=%0d", f,
                           fin_too_long, fin_len, e_long, e_len);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_oct_hex();
    test_short_escapes();
    test_errors();
    test_backpressure();
    test_too_long_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
